program_loader: RTL
===================

Name: program_loader

Overview:
- Writer side of the processor's instruction memory: accepts a stream of instruction words over a valid/ready handshake and writes them to consecutive addresses of a writable instruction RAM, starting at 0.
- Holds the processor core in reset while loading.
- Reports completion, word count, and an XOR checksum of the loaded program.
- Sits between the external programming interface (testbench or UART deframer) and the instruction RAM.

Parameters:
- INSTRUCTION_WIDTH, 10, instruction word width in bits.
- ADDR_BITS, 6, instruction address width; capacity is 2**ADDR_BITS words (64).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a load.
- length  input  ADDR_BITS+1  number of words to load; sampled when start is accepted.
- abort  input  1  cancel an active load.
- in_valid  input  1  in_data holds a word.
- in_data  input  INSTRUCTION_WIDTH  instruction word.
- in_ready  output  1  loader accepts a word this cycle.
- mem_we  output  1  instruction RAM write enable.
- mem_addr  output  ADDR_BITS  instruction RAM write address.
- mem_wdata  output  INSTRUCTION_WIDTH  instruction RAM write data.
- busy  output  1  load in progress.
- cpu_hold  output  1  holds the processor core in reset.
- done  output  1  last load completed successfully; level signal.
- error  output  1  one-cycle pulse on a rejected start or an abort.
- words_loaded  output  ADDR_BITS+1  words accepted in the current or last load.
- checksum  output  INSTRUCTION_WIDTH  XOR of all words accepted in the current or last load.

Behaviour:
- Reset (async, active-high): state IDLE. All outputs are 0, including mem_addr, mem_wdata, words_loaded and checksum.
- FSM states: IDLE, LOAD, DONE.
- Start acceptance:
  - A start in IDLE or DONE with 1 <= length <= 2**ADDR_BITS latches length, clears words_loaded, checksum and done, and enters LOAD on the next edge.
  - A start with length 0 or length > 2**ADDR_BITS is rejected: error pulses for 1 cycle at t+1, the state is unchanged, and done is unchanged.
- start while in LOAD is ignored. No error is raised.
- in_ready is combinational: (state == LOAD) && !abort.
- Transfer = in_valid && in_ready on a rising edge.
- Write timing: a transfer at edge t produces, from t until t+1:
  - mem_we = 1
  - mem_addr = previous words_loaded (low ADDR_BITS bits)
  - mem_wdata = the accepted word
  - All outputs are registered; write latency is exactly 1 cycle.
- On each transfer, words_loaded increments and checksum ^= in_data.
- mem_we is 0 in every cycle not preceded by a transfer.
- Back-to-back transfers are sustained at 1 word/cycle. in_valid low inserts bubbles with no writes.
- Completion: when the transfer makes words_loaded equal the latched length, the state becomes DONE on that same edge. busy = 0, done = 1, in_ready = 0. The final write is still presented that cycle.
- Addresses never wrap: length is capped at 64, so the highest address written is length-1.
- busy = (state == LOAD).
- cpu_hold = busy, or the final-write cycle (mem_we in DONE). The core is released only after the last word is in RAM.
- Abort in LOAD:
  - Any handshake in the abort cycle is discarded.
  - The next state is IDLE, with error = 1 for 1 cycle and done = 0.
  - A write already scheduled from the previous cycle's transfer completes normally.
  - words_loaded and checksum keep their partial values.
- abort outside LOAD is ignored.
- Reset mid-load returns to IDLE immediately with all outputs cleared. RAM contents are not the loader's concern.
- DONE persists until the next accepted start or reset.

Decomposition:
- Shared package holds:
  - constants INSTRUCTION_WIDTH = 10 and ADDR_BITS = 6;
  - derived constant MEM_DEPTH = 2**ADDR_BITS;
  - the loader state enum (IDLE, LOAD, DONE).
- One natural sub-module: instruction_ram, a 64x10 RAM with a synchronous write port (we/waddr/wdata) and an asynchronous read port (address -> instruction).
- Top-level integration pairs program_loader with instruction_ram, replacing the file-initialised ROM when runtime loading is enabled.

Test Plan:
1. Basic load:
   - Stimulus: reset, start with length = 3, then words 0x001, 0x3FF, 0x155 on consecutive cycles.
   - Response: writes to addresses 0, 1, 2 in the cycles after each transfer. done = 1, words_loaded = 3, checksum = 0x2AB, cpu_hold falls 1 cycle after the last transfer, and the RAM read-back matches.
2. Rejected starts:
   - Stimulus: start with length = 0, then start with length = 65.
   - Response: error pulses 1 cycle each, the state stays IDLE, busy = 0, and mem_we never asserts.
3. Full-capacity load with bubbles:
   - Stimulus: length = 64, in_valid toggling 1/0.
   - Response: exactly 64 writes at addresses 0..63 with no wrap. done = 1, words_loaded = 64.
4. Abort:
   - Stimulus: length = 10, 4 words accepted, then abort asserted together with in_valid.
   - Response: in_ready = 0 in the abort cycle, the 5th word is not written, the 4th write completes. State IDLE, error pulse, done = 0, words_loaded = 4.
5. Async reset mid-load:
   - Stimulus: length = 8, reset asserted between edges after 2 words.
   - Response: all outputs go to 0 immediately without waiting for a clock edge. A new start with length = 1 then loads address 0 correctly.
6. Reload from DONE:
   - Stimulus: complete a 3-word load, then start with length = 2 and words 0x00F, 0x0F0.
   - Response: done clears on start, then sets again. checksum = 0x0FF, words_loaded = 2, and start pulses during LOAD are ignored.

Source files
------------

// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared widths, memory depth and loader state encoding.
package program_loader_pkg;
  localparam int INSTRUCTION_WIDTH = 10;
  localparam int ADDR_BITS = 6;
  localparam int MEM_DEPTH = 2 ** ADDR_BITS;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
endpackage

// File: rtl/instruction_ram.sv
// instruction_ram: 64x10 instruction store, synchronous write, asynchronous read.
module instruction_ram
  import program_loader_pkg::*;
(
  input  logic                         clk,
  input  logic                         we,
  input  logic [ADDR_BITS-1:0]         waddr,
  input  logic [INSTRUCTION_WIDTH-1:0] wdata,
  input  logic [ADDR_BITS-1:0]         address,
  output logic [INSTRUCTION_WIDTH-1:0] instruction
);
  logic [INSTRUCTION_WIDTH-1:0] mem [MEM_DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign instruction = mem[address];
endmodule

// File: rtl/program_loader.sv
// program_loader: streams instruction words into the instruction RAM while holding the core in reset.
module program_loader
  import program_loader_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_BITS:0]           length,
  input  logic                         abort,
  input  logic                         in_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] in_data,
  output logic                         in_ready,
  output logic                         mem_we,
  output logic [ADDR_BITS-1:0]         mem_addr,
  output logic [INSTRUCTION_WIDTH-1:0] mem_wdata,
  output logic                         busy,
  output logic                         cpu_hold,
  output logic                         done,
  output logic                         error,
  output logic [ADDR_BITS:0]           words_loaded,
  output logic [INSTRUCTION_WIDTH-1:0] checksum
);
  localparam logic [ADDR_BITS:0] MAX_LEN = (ADDR_BITS + 1)'(MEM_DEPTH);
  state_e state_q, state_d;
  logic [ADDR_BITS:0] len_q, len_d, words_q, words_d;
  logic [INSTRUCTION_WIDTH-1:0] sum_q, sum_d, wdata_q, wdata_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic we_q, we_d, error_q, error_d, xfer, len_ok;
  assign in_ready = (state_q == LOAD) && !abort;
  assign xfer = in_valid && in_ready;
  assign len_ok = (length != '0) && (length <= MAX_LEN);
  assign busy = state_q == LOAD;
  assign done = state_q == DONE;
  // keep the core held until the final word has actually landed in RAM
  assign cpu_hold = busy || (we_q && done);
  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign error = error_q;
  assign words_loaded = words_q;
  assign checksum = sum_q;
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    words_d = words_q;
    sum_d = sum_q;
    we_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    error_d = 1'b0;
    if (state_q == LOAD) begin
      if (abort) begin
        state_d = IDLE;
        error_d = 1'b1;
      end else if (xfer) begin
        we_d = 1'b1;
        addr_d = words_q[ADDR_BITS-1:0];
        wdata_d = in_data;
        words_d = words_q + 1'b1;
        sum_d = sum_q ^ in_data;
        state_d = (words_d == len_q) ? DONE : LOAD;
      end
    end else if (start) begin
      if (len_ok) begin
        state_d = LOAD;
        len_d = length;
        words_d = '0;
        sum_d = '0;
      end else error_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      len_q <= '0;
      words_q <= '0;
      sum_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      words_q <= words_d;
      sum_q <= sum_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      error_q <= error_d;
    end
  end
endmodule
